// File: rtl/mem_access_unit_if.sv
// Data-memory port of the load/store unit: one valid/ready request channel
// plus a read-response channel.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: byte/half/word accesses over a valid/ready port.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts a stuck transaction.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] rd2,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  access_err,
  mem_access_unit_if.master     mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [DATA_WIDTH-1:0] load_data_reg, load_data_next;
  logic [2:0]            funct3_reg, funct3_next;
  logic                  we_reg, we_next;
  logic                  err_reg, err_next;

  logic                  accept;
  logic                  bad_access;
  logic                  timeout;
  logic                  in_req;
  logic [3:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [7:0]            rsp_byte [4];
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] load_ext;

  assign accept = (state_reg == IDLE) && op_valid && (MemRead || MemWrite);
  assign in_req = (state_reg == REQ);

  // Classify the presented op; bad accesses never reach the memory port.
  always_comb begin
    logic store_ok, load_ok, misaligned;
    store_ok   = funct3 inside {3'b000, 3'b001, 3'b010};
    load_ok    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                 ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    bad_access = (MemRead && MemWrite) || (MemWrite && !store_ok) ||
                 (MemRead && !load_ok) || misaligned;
  end

  // Per-lane strobe and store-data replication, plus response byte split.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      always_comb begin
        case (funct3_reg[1:0])
          2'b00: begin
            lane_strb[gi]          = (addr_reg[1:0] == LANE);
            lane_wdata[8*gi +: 8]  = data_reg[7:0];
          end
          2'b01: begin
            lane_strb[gi]          = (addr_reg[1] == LANE[1]);
            lane_wdata[8*gi +: 8]  = data_reg[8*(gi%2) +: 8];
          end
          default: begin
            lane_strb[gi]          = 1'b1;
            lane_wdata[8*gi +: 8]  = data_reg[8*gi +: 8];
          end
        endcase
      end
      assign rsp_byte[gi] = mem.mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte = rsp_byte[addr_reg[1:0]];
    sel_half = addr_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_ext = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Fires in the last cycle of the budget so DONE lands TIMEOUT_CYCLES after REQ entry.
  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE)
      cnt_next = '0;
    else if (state_reg == REQ || state_reg == WAIT_RSP)
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    funct3_next    = funct3_reg;
    we_next        = we_reg;
    err_next       = err_reg;
    load_data_next = load_data_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          addr_next   = ALUResult;
          data_next   = rd2;
          funct3_next = funct3;
          we_next     = MemWrite && !MemRead;
          err_next    = bad_access;
          if (bad_access) begin
            load_data_next = '0;
            state_next     = DONE;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          state_next = we_reg ? DONE : WAIT_RSP;
        end else if (timeout) begin
          err_next       = 1'b1;
          load_data_next = '0;
          state_next     = DONE;
        end
      end
      WAIT_RSP: begin
        if (mem.mem_rsp_valid) begin
          load_data_next = load_ext;
          state_next     = DONE;
        end else if (timeout) begin
          err_next       = 1'b1;
          load_data_next = '0;
          state_next     = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      data_reg      <= '0;
      funct3_reg    <= '0;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
      load_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      funct3_reg    <= funct3_next;
      we_reg        <= we_next;
      err_reg       <= err_next;
      load_data_reg <= load_data_next;
    end
  end

  // Request fields are zero outside REQ; loads never carry strobes or data.
  assign mem.mem_req_valid = in_req;
  assign mem.mem_we        = in_req && we_reg;
  assign mem.mem_addr      = in_req ? {addr_reg[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem.mem_wdata     = (in_req && we_reg) ? lane_wdata : '0;
  assign mem.mem_wstrb     = (in_req && we_reg) ? lane_strb : '0;

  assign stall      = accept || (state_reg == REQ) || (state_reg == WAIT_RSP);
  assign done       = (state_reg == DONE);
  assign access_err = (state_reg == DONE) && err_reg;
  assign load_data  = load_data_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every
// output each cycle, and literal per-test expectations pin the model.
module tb_mem_access_unit;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUResult = '0;
  logic [31:0] rd2 = '0;
  logic        stall, done, access_err;
  logic [31:0] load_data;

  mem_access_unit_if mif ();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .funct3(funct3), .ALUResult(ALUResult), .rd2(rd2),
    .stall(stall), .done(done), .load_data(load_data),
    .access_err(access_err), .mem(mif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  string tname = "reset";

  // Model state for the transaction in flight (cycle 0 = accept cycle).
  logic        act = 1'b0;
  int          cyc = 0;
  int          m_lat = 0;
  int          m_hs = 0;
  logic        m_bad = 1'b0, m_err = 1'b0, m_store = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ld = '0, held_ld = '0;
  logic [3:0]  m_strb = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h at %0t", tname, nm, got, exp, $time);
    end
  endtask

  function automatic logic f_bad(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
    if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
    if (f3[1:0] == 2'd1 && (a % 2) != 0) return 1'b1;
    if (f3[1:0] == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_strb(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'd0) return 4'(1 << (a % 4));
    if (f3[1:0] == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (r >> (8 * (a % 4))) % 256;
      if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'd1) begin
      v = (r >> (16 * ((a % 4) / 2))) % 65536;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_stall", 32'(stall), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(access_err), 0);
      chk("rst_load", load_data, 0);
      chk("rst_req", 32'(mif.mem_req_valid), 0);
      chk("rst_we", 32'(mif.mem_we), 0);
      chk("rst_addr", mif.mem_addr, 0);
      chk("rst_wdata", mif.mem_wdata, 0);
      chk("rst_wstrb", 32'(mif.mem_wstrb), 0);
    end else begin
      logic e_stall, e_done, e_req;
      e_stall = act && (cyc < m_lat);
      e_done  = act && (cyc == m_lat);
      e_req   = act && !m_bad && (cyc >= 1) && (cyc <= m_hs);
      chk("stall", 32'(stall), 32'(e_stall));
      chk("done", 32'(done), 32'(e_done));
      chk("req_valid", 32'(mif.mem_req_valid), 32'(e_req));
      chk("access_err", 32'(access_err), 32'(e_done && m_err));
      chk("load_data", load_data, (e_done && !m_store) ? m_ld : held_ld);
      if (e_req) begin
        chk("mem_addr", mif.mem_addr, m_addr & 32'hFFFF_FFFC);
        chk("mem_we", 32'(mif.mem_we), 32'(m_store));
        chk("mem_wstrb", 32'(mif.mem_wstrb), m_store ? 32'(m_strb) : 0);
        if (m_store) chk("mem_wdata", mif.mem_wdata, m_wdata);
      end
    end
  end

  // One transaction. rdy_d: REQ cycles before ready; rsp_d: cycles from handshake to
  // response. A response pulse with wrong data is also driven in the handshake cycle.
  task automatic do_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d2, input int rdy_d,
                       input int rsp_d, input logic [31:0] rdat, input logic [31:0] lit_ld,
                       input logic [3:0] lit_strb, input logic [31:0] lit_wd,
                       input logic tmo, input int abort_at);
    @(posedge clk); #2;
    tname   = nm;
    m_bad   = f_bad(rd, wr, f3, a);
    m_store = wr && !m_bad;
    m_err   = m_bad || tmo;
    m_addr  = a;
    m_strb  = f_strb(f3, a);
    m_wdata = f_wdata(f3, d2);
    m_ld    = m_err ? 32'h0 : (m_store ? held_ld : f_load(f3, a, rdat));
    m_hs    = 1 + rdy_d;
    if (m_bad)        m_lat = 1;
    else if (tmo)     m_lat = 1 + TMO;
    else if (m_store) m_lat = 2 + rdy_d;
    else              m_lat = 2 + rdy_d + rsp_d;
    op_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; rd2 = d2;
    mif.mem_req_ready = 1'b1;
    cyc = 0; act = 1'b1;
    for (int c = 1; c <= m_lat; c++) begin
      @(posedge clk); #2;
      cyc = c;
      op_valid = 1'b0;
      if (abort_at != 0 && c == abort_at) begin
        rst_n = 1'b0; act = 1'b0; held_ld = '0;
        mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0;
        return;
      end
      mif.mem_req_ready = (c == m_hs);
      mif.mem_rsp_valid = !wr && ((c == m_hs) || (c == m_hs + rsp_d));
      mif.mem_rdata     = (c == m_hs) ? ~rdat : ((c == m_hs + rsp_d) ? rdat : 32'h0);
      if ((c == 1 && !m_bad) || c == m_lat) begin
        @(negedge clk); #1;
        if (c == 1 && !m_bad) begin
          chk("lit_wstrb", 32'(mif.mem_wstrb), 32'(lit_strb));
          if (m_store) chk("lit_wdata", mif.mem_wdata, lit_wd);
        end
        if (c == m_lat) begin
          chk("lit_done", 32'(done), 1);
          if (!m_store) chk("lit_load", load_data, lit_ld);
        end
      end
    end
    @(posedge clk); #2;
    act = 1'b0;
    if (!m_store) held_ld = m_ld;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = '0;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    //     name        rd  wr  f3    addr          rd2           rdy rsp rdata         lit_ld        strb   lit_wd       tmo abort
    do_op("sw_100",   0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0,        32'h0,        4'hF, 32'hDEADBEEF, 0, 0);
    do_op("sb_103",   0, 1, 3'd0, 32'h103, 32'h000000A5, 0, 1, 32'h0,        32'h0,        4'h8, 32'hA5A5A5A5, 0, 0);
    do_op("lbu_103",  1, 0, 3'd4, 32'h103, 32'h0,        0, 1, 32'hA5000000, 32'h000000A5, 4'h0, 32'h0,        0, 0);
    do_op("lb_103",   1, 0, 3'd0, 32'h103, 32'h0,        0, 1, 32'hA5000000, 32'hFFFFFFA5, 4'h0, 32'h0,        0, 0);
    do_op("lh_202",   1, 0, 3'd1, 32'h202, 32'h0,        3, 2, 32'h8001FFFF, 32'hFFFF8001, 4'h0, 32'h0,        0, 0);
    do_op("sh_102",   0, 1, 3'd1, 32'h102, 32'h1234ABCD, 1, 1, 32'h0,        32'h0,        4'hC, 32'hABCDABCD, 0, 0);
    do_op("lw_mis",   1, 0, 3'd2, 32'h101, 32'h0,        0, 1, 32'h12345678, 32'h0,        4'h0, 32'h0,        0, 0);
    do_op("lhu_200",  1, 0, 3'd5, 32'h200, 32'h0,        0, 3, 32'h8001FFFF, 32'h0000FFFF, 4'h0, 32'h0,        0, 0);
    do_op("rd_wr",    1, 1, 3'd2, 32'h100, 32'h11111111, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0, 0);
    do_op("sb_101",   0, 1, 3'd0, 32'h101, 32'h0000017F, 2, 1, 32'h0,        32'h0,        4'h2, 32'h7F7F7F7F, 0, 0);
    do_op("s_f3_011", 0, 1, 3'd3, 32'h100, 32'h22222222, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0, 0);
    do_op("lw_204",   1, 0, 3'd2, 32'h204, 32'h0,        0, 1, 32'h12345678, 32'h12345678, 4'h0, 32'h0,        0, 0);
    do_op("l_f3_110", 1, 0, 3'd6, 32'h204, 32'h0,        0, 1, 32'h12345678, 32'h0,        4'h0, 32'h0,        0, 0);
    do_op("lb_102",   1, 0, 3'd0, 32'h102, 32'h0,        1, 2, 32'h00800000, 32'hFFFFFF80, 4'h0, 32'h0,        0, 0);
    do_op("sh_mis",   0, 1, 3'd1, 32'h103, 32'h0000BEEF, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0, 0);

    // op_valid without a read or write must not start anything.
    @(posedge clk); #2;
    tname = "no_op"; op_valid = 1'b1; funct3 = 3'd2; ALUResult = 32'h40;
    @(posedge clk); #2;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while waiting for a load response, then a stale response.
    do_op("rst_wait", 1, 0, 3'd2, 32'h300, 32'h0, 0, 5, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0, 0, 3);
    tname = "stale_rsp";
    @(posedge clk); #2;
    mif.mem_rsp_valid = 1'b1; mif.mem_req_ready = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #2;
    mif.mem_rsp_valid = 1'b0; mif.mem_req_ready = 1'b0; mif.mem_rdata = '0;
    repeat (3) @(posedge clk);

`ifdef MEM_TIMEOUT_EN
    do_op("lw_tmo",   1, 0, 3'd2, 32'h400, 32'h0, 0, 100000, 32'h0, 32'h0, 4'h0, 32'h0, 1, 0);
`endif
    do_op("lw_after", 1, 0, 3'd2, 32'h408, 32'h0, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 4'h0, 32'h0, 0, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit in the memory stage. It consumes the execute-stage result (ALUResult as the effective address, rd2 as store data) and drives a valid/ready data-memory port. It handles byte, half-word and word accesses, including byte-lane strobes, load extraction and sign/zero extension. It stalls the pipeline for the whole transaction and flags misaligned or illegal accesses instead of issuing them.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  memory op presented this cycle.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- funct3  input  3  access size/sign (RV32I encoding).
- ALUResult  input  ADDR_WIDTH  effective byte address.
- rd2  input  DATA_WIDTH  store data, right-aligned.
- stall  output  1  hold upstream pipeline.
- done  output  1  one-cycle completion pulse.
- load_data  output  DATA_WIDTH  extended load result; valid when done is high.
- access_err  output  1  misaligned/illegal/timeout; valid when done is high.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  output  DATA_WIDTH  lane-replicated store data.
- mem_wstrb  output  4  byte enables.
- mem_rsp_valid  input  1  read data valid.
- mem_rdata  input  DATA_WIDTH  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including load_data, and mem_req_valid drops immediately. An in-flight transaction is abandoned; a late mem_rsp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: when op_valid & (MemRead|MemWrite), capture addr, data, funct3 and direction.
  - Legal access: go to REQ.
  - Illegal or misaligned access: go to DONE with error set.
  - stall is asserted combinationally in the accept cycle.
- Illegal accesses:
  - MemRead & MemWrite both high.
  - Store funct3 not in {000,001,010}.
  - Load funct3 not in {000,001,010,100,101}.
- Misaligned accesses: half with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_req_ready.
  - On handshake, a store goes to DONE and a load goes to WAIT_RSP.
  - mem_req_ready while not in REQ is ignored.
- WAIT_RSP: on mem_rsp_valid, register the extracted load value and go to DONE. mem_rsp_valid in the same cycle as the request handshake is not accepted; the response must come at least one cycle later.
- DONE: done=1 and stall=0 for exactly one cycle, then go to IDLE. load_data holds until the next DONE. access_err is 1 only in an error DONE, and load_data=0 in that case.
- stall=1 in the IDLE accept cycle, REQ and WAIT_RSP; 0 otherwise.
- Minimum latency: store 2 cycles (accept→REQ→DONE), load 3 cycles, error 1 cycle.
- Store strobes:
  - SB: wstrb=1<<addr[1:0], wdata={4{rd2[7:0]}}.
  - SH: wstrb=addr[1]?1100:0011, wdata={2{rd2[15:0]}}.
  - SW: wstrb=1111, wdata=rd2.
- Load extraction: select byte by addr[1:0] or half by addr[1].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- Loads drive mem_wstrb=0 and mem_we=0.
- op_valid is ignored outside IDLE. Upstream must hold its inputs while stall=1.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8+-bit counter clears on entry to REQ and counts while in REQ or WAIT_RSP. When it reaches TIMEOUT_CYCLES without the awaited handshake, the unit goes to DONE with access_err=1, load_data=0, and mem_req_valid dropped.
- Undefined: no counter; the unit waits indefinitely.

Test Plan:
- SW addr 0x100, rd2=0xDEADBEEF, ready on first REQ cycle → mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done 2 cycles after accept, access_err=0.
- SB addr 0x103, rd2=0x000000A5 → wstrb=1000, wdata=0xA5A5A5A5. Then LBU at 0x103 with rdata=0xA5000000 → load_data=0x000000A5; LB at the same address → 0xFFFFFFA5.
- LH addr 0x202, rdata=0x8001FFFF, mem_req_ready delayed 3 cycles, rsp 2 cycles later → mem_req_valid and request fields stable throughout, load_data=0xFFFF8001, stall high until DONE.
- LW addr 0x101 → no mem_req_valid, done next cycle with access_err=1, load_data=0. Same result for MemRead&MemWrite=1 and for store funct3=011.
- Assert rst_n low during WAIT_RSP, release, then drive a stale mem_rsp_valid → all outputs 0, state IDLE, no done pulse.
- MEM_TIMEOUT_EN defined, LW with no response → done with access_err=1 exactly TIMEOUT_CYCLES cycles after entering REQ.
